// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract sequencer.
// The master drives the request and the slave returns status and result.
interface serial_addsub_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full-adder slice stepped LSB first over two
// latched operands, with carry FF, result shift register and start/busy/done.
module serial_addsub_ctrl #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_addsub_ctrl_if.slave   bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   sh_a;
    logic [W-1:0]   sh_b;
    logic [W-1:0]   res;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic           busy_r;
    logic           done_r;
    logic           cout_r;
    logic           ovf_r;
    logic           s;
    logic           c_next;

    // Single full-adder slice on the current LSBs.
    always_comb begin
        s      = sh_a[0] ^ sh_b[0] ^ carry;
        c_next = (sh_a[0] & sh_b[0]) | ((sh_a[0] ^ sh_b[0]) & carry);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            res    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        // Subtract is a + ~b + 1: invert B and seed the carry with op.
                        sh_a   <= bus.a;
                        sh_b   <= bus.op ? ~bus.b : bus.b;
                        carry  <= bus.op;
                        cnt    <= '0;
                        res    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    res   <= {s, res[W-1:1]};
                    carry <= c_next;
                    if (cnt == CW'(W - 1)) begin
                        // Carry into the MSB xor carry out of it flags signed overflow.
                        ovf_r  <= carry ^ c_next;
                        cout_r <= c_next;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = res;
    assign bus.cout   = cout_r;
    assign bus.ovf    = ovf_r;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_serial_addsub_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_addsub_ctrl_if #(.W(W)) bus ();

    serial_addsub_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1..W = busy cycles, W+1 = done cycle.
    int           ph;
    logic [W-1:0] er, pr;
    logic         ec, eo, pc, po;

    always @(posedge clk or posedge rst) begin
        logic [W:0] sum;
        if (rst) begin
            ph = 0; er = '0; ec = 1'b0; eo = 1'b0;
        end else if (ph == 0) begin
            if (bus.start) begin
                if (bus.op)
                    sum = {1'b0, bus.a} + {1'b0, ~bus.b} + (W+1)'(1);
                else
                    sum = {1'b0, bus.a} + {1'b0, bus.b};
                pr = sum[W-1:0];
                pc = sum[W];
                if (bus.op)
                    po = (bus.a[W-1] != bus.b[W-1]) && (pr[W-1] != bus.a[W-1]);
                else
                    po = (bus.a[W-1] == bus.b[W-1]) && (pr[W-1] != bus.a[W-1]);
                er = '0;
                ph = 1;
            end
        end else if (ph == W + 1) begin
            ph = 0;
        end else begin
            ph = ph + 1;
            if (ph == W + 1) begin
                er = pr; ec = pc; eo = po;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(ph >= 1 && ph <= W));
        chk("done", 32'(bus.done), 32'(ph == W + 1));
        if (bus.busy && bus.done) chk("busy_done_overlap", 32'(1), 32'(0));
        if (ph == 0 || ph == W + 1) begin
            chk("result", 32'(bus.result), 32'(er));
            chk("cout",   32'(bus.cout),   32'(ec));
            chk("ovf",    32'(bus.ovf),    32'(eo));
        end
    end

    // Issue one operation from a negedge, check latency, busy length and literal result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                          input logic [W-1:0] xr, input logic xc, input logic xo, input string nm);
        int n, nb;
        bus.start = 1'b1; bus.a = ta; bus.b = tb; bus.op = top;
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~ta; bus.b = ~tb; bus.op = ~top;
        n = 1; nb = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) nb++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(W + 1));
        chk({nm, "_busycycles"}, 32'(nb), 32'(W));
        chk({nm, "_result"}, 32'(bus.result), 32'(xr));
        chk({nm, "_cout"}, 32'(bus.cout), 32'(xc));
        chk({nm, "_ovf"}, 32'(bus.ovf), 32'(xo));
        @(negedge clk);
    endtask

    initial begin
        int n, last;
        total = 0; bad = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", 32'(bus.result), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");

        // Second start during busy cycle 3 must be ignored.
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.op = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h22; bus.b = 8'h22;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin @(negedge clk); n++; end
        chk("ignore_result", 32'(bus.result), 32'h02);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", 32'(bus.result), 32'h02);
        end

        // Reset in busy cycle 4 aborts with no done pulse.
        bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h33; bus.op = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_done", 32'(bus.done), 32'h0);
        chk("abort_result", 32'(bus.result), 32'h0);
        chk("abort_cout", 32'(bus.cout), 32'h0);
        chk("abort_ovf", 32'(bus.ovf), 32'h0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        run_op(8'h55, 8'h33, 1'b0, 8'h88, 1'b0, 1'b1, "add_55_33");

        // Start held high: done every W+2 cycles, operands changing every cycle.
        bus.start = 1'b1;
        last = -1;
        for (int c = 0; c < 80; c++) begin
            bus.a = W'($urandom); bus.b = W'($urandom); bus.op = c[0];
            @(negedge clk);
            if (bus.done) begin
                if (last >= 0) chk("b2b_interval", 32'(c - last), 32'(W + 2));
                last = c;
            end
        end
        chk("b2b_seen_done", 32'(last >= 0), 32'h1);
        bus.start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Random sparse starts, including starts landing in RUN/DONE.
        for (int c = 0; c < 400; c++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 1'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer for the calculator datapath.
- Latches two W-bit operands and steps a single one-bit full-adder slice across them, LSB first, one bit per clock.
- Carries the running carry in a flip-flop and assembles the result in a shift register.
- Reports the result, carry-out and signed overflow with a start/busy/done handshake.

Parameters:
- W, 8, operand and result width in bits (W >= 2).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse, result valid
- result  output  W  sum/difference; held until the next accepted start
- cout  output  1  final carry out (subtract: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: clear all state asynchronously: FSM=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, bit counter=0, carry FF=0, operand shift registers=0. Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on a rising edge with start=1:
  - Load shift register A with a.
  - Load shift register B with b when op=0, or with ~b when op=1.
  - Set carry FF to op.
  - Clear the counter and clear result.
- RUN, one bit per cycle:
  - s = A[0] ^ B[0] ^ c.
  - c_next = (A[0]&B[0]) | ((A[0]^B[0])&c).
  - Shift A and B right by one.
  - Shift result right with s entering at bit W-1.
  - Update carry FF to c_next.
  - Increment the counter.
- RUN, last bit (counter = W-1):
  - ovf <= c ^ c_next (carry into MSB xor carry out).
  - cout <= c_next.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Output hold: result, cout and ovf stay stable from DONE until the edge that accepts the next start.
- Timing: start accepted at edge k.
  - busy=1 during cycles k+1 .. k+W (W cycles).
  - done=1 during cycle k+W+1.
  - Total latency from start to done is W+1 clocks.
- busy and done are never high together.
- start while in RUN or DONE is ignored. No queuing and no effect on the in-flight operation.
- Operands a, b and op may change freely after the accepting edge.
- Back-to-back: start held high continuously gives a new operation accepted in the first IDLE cycle after DONE. Throughput is one operation per W+2 cycles.
- Arithmetic is modulo 2^W, with no saturation.
- ovf meaning:
  - Add: operands of equal sign produce a result of the other sign.
  - Subtract: operands of differing sign produce a result whose sign differs from a.
- The counter width is clog2(W). Compare against W-1; never wrap past it.

Test Plan:
- Reset, then add 0x0F+0x01 (W=8) -> busy high 8 cycles, done 9 clocks after the accepting edge, result=0x10, cout=0, ovf=0.
- Add 0x7F+0x01 -> result=0x80, cout=0, ovf=1. Add 0xFF+0x01 -> result=0x00, cout=1, ovf=0.
- Subtract 0x05-0x07 -> result=0xFE, cout=0 (borrow), ovf=0. Subtract 0x80-0x01 -> result=0x7F, cout=1, ovf=1.
- Pulse start with 0x01+0x01, then pulse start with 0x22+0x22 at busy cycle 3 -> second request ignored, result=0x02. Result holds 0x02 across 5 idle cycles until the next start.
- Assert rst at busy cycle 4 of 0x55+0x33 -> busy/done/result/cout/ovf all 0 immediately, no done pulse. Release rst, then 0x55+0x33 -> result=0x88, ovf=1.
- Hold start=1 continuously with alternating operands -> done pulses every 10 cycles, each result correct, busy never overlaps done.
